// File: rtl/lbp_pkg.sv
// Shared geometry and state encoding for the LBP host memory responder.
package lbp_pkg;

  localparam int unsigned IMG_W   = 128;
  localparam int unsigned IMG_H   = 128;
  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned IMG_PIX = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    LOAD,
    SERVE,
    DONE
  } host_state_t;

endpackage

// File: rtl/lbp_img_ram.sv
// Single-port synchronous RAM with a registered, enable-held read port.
module lbp_img_ram #(
  parameter int unsigned Depth = 16384,
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic [AddrW-1:0] addr,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register resets to zero and holds between reads; the array itself is not reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/lbp_host.sv
// Memory-side responder for the LBP engine: loads the gray image, serves reads,
// captures result writes and exposes them for readback once the engine finishes.
module lbp_host #(
  parameter int unsigned IMG_W  = lbp_pkg::IMG_W,
  parameter int unsigned IMG_H  = lbp_pkg::IMG_H,
  parameter int unsigned ADDR_W = lbp_pkg::ADDR_W,
  parameter int unsigned DATA_W = lbp_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic              gray_ready,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic              err
);

  import lbp_pkg::*;

  localparam int unsigned PixN  = IMG_W * IMG_H;
  localparam int unsigned PixAw = $clog2(PixN);
  localparam int unsigned CntW  = ADDR_W + 1;

  function automatic logic in_img(logic [ADDR_W-1:0] a);
    return 32'(a) < PixN;
  endfunction

  host_state_t       state_q, state_d;
  logic              arm_q;
  logic [PixAw-1:0]  ld_cnt_q, ld_cnt_d;
  logic [CntW-1:0]   wr_count_q, wr_count_d;
  logic              err_q, err_d;
  logic              rd_valid_q;

  logic              ld_fire;
  logic              gray_we, gray_re;
  logic [PixAw-1:0]  gray_ram_addr;
  logic              res_we, res_re;
  logic [PixAw-1:0]  res_ram_addr;

  always_comb begin
    ld_fire       = (state_q == LOAD) && arm_q && ld_valid;
    gray_we       = ld_fire;
    gray_re       = (state_q == SERVE) && gray_req && in_img(gray_addr);
    gray_ram_addr = (state_q == LOAD) ? ld_cnt_q : gray_addr[PixAw-1:0];
    res_we        = (state_q == SERVE) && lbp_valid && in_img(lbp_addr);
    res_re        = (state_q == DONE) && rd_en && in_img(rd_addr);
    res_ram_addr  = (state_q == DONE) ? rd_addr[PixAw-1:0] : lbp_addr[PixAw-1:0];
  end

  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    wr_count_d = wr_count_q;
    err_d      = err_q;
    case (state_q)
      LOAD: begin
        if (ld_fire) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == PixAw'(PixN - 1)) begin
            state_d = SERVE;
          end
        end
        if (lbp_valid) begin
          err_d = 1'b1;
        end
      end
      SERVE: begin
        if ((gray_req && !in_img(gray_addr)) || (lbp_valid && !in_img(lbp_addr))) begin
          err_d = 1'b1;
        end
        if (res_we && (wr_count_q != CntW'(PixN))) begin
          wr_count_d = wr_count_q + 1'b1;
        end
        // The completeness check sees a write strobed in the same cycle as finish.
        if (finish) begin
          state_d = DONE;
          if (wr_count_d != CntW'(PixN)) begin
            err_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (lbp_valid) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LOAD;
      arm_q      <= 1'b0;
      ld_cnt_q   <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_q      <= 1'b1;
      ld_cnt_q   <= ld_cnt_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
      rd_valid_q <= (state_q == DONE) && rd_en;
    end
  end

  lbp_img_ram #(
    .Depth (PixN),
    .Width (DATA_W)
  ) u_gray_ram (
    .clk   (clk),
    .reset (reset),
    .we    (gray_we),
    .re    (gray_re),
    .addr  (gray_ram_addr),
    .wdata (ld_data),
    .rdata (gray_data)
  );

  lbp_img_ram #(
    .Depth (PixN),
    .Width (DATA_W)
  ) u_res_ram (
    .clk   (clk),
    .reset (reset),
    .we    (res_we),
    .re    (res_re),
    .addr  (res_ram_addr),
    .wdata (lbp_data),
    .rdata (rd_data)
  );

  assign ld_ready   = (state_q == LOAD) && arm_q;
  assign gray_ready = (state_q == SERVE);
  assign done       = (state_q == DONE);
  assign wr_count   = wr_count_q;
  assign err        = err_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: doc/lbp_host.md
# lbp_host

Memory-side responder for the LBP engine. Loads a 128×128 8-bit gray image from a byte stream and serves it over the `gray_*` request interface. Captures the engine's `lbp_*` result writes into a result memory. After the engine raises `finish`, exposes the results through a readback port. Sits between the testbench or system loader and the LBP engine: it is the far end of both of the engine's memory interfaces.

## Interface
Parameters:
- `IMG_W`, 128, image width in pixels
- `IMG_H`, 128, image height in pixels
- `ADDR_W`, 14, pixel address width; requires 2^`ADDR_W` ≥ `IMG_W`·`IMG_H`
- `DATA_W`, 8, pixel and LBP code width

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `ld_valid`  in  1  load beat valid
- `ld_ready`  out  1  load beat accepted
- `ld_data`  in  `DATA_W`  gray pixel, raster order
- `gray_req`  in  1  engine read request
- `gray_addr`  in  `ADDR_W`  engine read address
- `gray_ready`  out  1  image available for reading
- `gray_data`  out  `DATA_W`  registered read data
- `lbp_valid`  in  1  engine result write strobe
- `lbp_addr`  in  `ADDR_W`  result address
- `lbp_data`  in  `DATA_W`  result code
- `finish`  in  1  engine completion
- `rd_en`  in  1  readback request
- `rd_addr`  in  `ADDR_W`  readback address
- `rd_data`  out  `DATA_W`  readback data
- `rd_valid`  out  1  `rd_data` valid
- `done`  out  1  results frozen and readable
- `wr_count`  out  `ADDR_W`+1  result writes accepted
- `err`  out  1  sticky protocol error

## Operation
- **States:** LOAD → SERVE → DONE. DONE is terminal until reset.
- **LOAD**
  - `ld_ready`=1.
  - Each beat with `ld_valid`&`ld_ready` writes the gray RAM at `ld_cnt`, then `ld_cnt`++.
  - The beat where `ld_cnt`=`IMG_W`·`IMG_H`−1 moves to SERVE.
  - `gray_req` and `lbp_valid` are ignored.
  - `lbp_valid` in LOAD sets `err`.
- **SERVE**
  - `gray_ready`=1, `ld_ready`=0.
  - When `gray_req`=1, `gray_data` ← gray RAM[`gray_addr`] on the next edge.
  - When `gray_req`=0, `gray_data` holds its value.
  - `lbp_valid`=1 writes result RAM[`lbp_addr`] ← `lbp_data` and increments `wr_count`.
  - `wr_count` saturates at `IMG_W`·`IMG_H`. Duplicate addresses overwrite and are still counted.
  - Address ≥ `IMG_W`·`IMG_H` on `gray_req` or `lbp_valid` sets `err`, and that access is dropped.
- **SERVE → DONE** on `finish`=1.
  - A same-cycle `lbp_valid` write is committed first.
  - `err` is set if the final `wr_count` (including that write) ≠ `IMG_W`·`IMG_H`.
- **DONE**
  - `done`=1, `gray_ready`=0.
  - `rd_en` returns result RAM[`rd_addr`] on `rd_data` with `rd_valid`=1 one cycle later.
  - `lbp_valid` in DONE sets `err`, and the write is dropped.
  - `rd_en` outside DONE is ignored (`rd_valid` stays 0).
- `ld_valid` outside LOAD is ignored.

## Timing
- **Reset values:** state=LOAD, `ld_ready`=0 for the first cycle after reset release then 1, `gray_ready`=0, `gray_data`=0, `rd_data`=0, `rd_valid`=0, `done`=0, `wr_count`=0, `err`=0, `ld_cnt`=0. RAM contents are not reset.
- **Reset mid-operation:** immediate return to LOAD. Counters and flags cleared; a new full image load is required.
- **Latencies:**
  - Gray read: 1 cycle, address sampled with `gray_req`.
  - Readback: 1 cycle.
  - Result write: visible to readback the cycle after the strobe.
- `gray_ready` rises the cycle after the last load beat and falls the cycle after `finish` is sampled.
- `done` rises the cycle after `finish`.
- Back-to-back requests every cycle are supported on all ports. No stalls are generated in SERVE or DONE.
- `err` is sticky until reset.

## Structure
- **Package `lbp_pkg`:** `IMG_W`, `IMG_H`, `ADDR_W`, `DATA_W`, derived `IMG_PIX`=`IMG_W`·`IMG_H`, and enum `host_state_t` {LOAD, SERVE, DONE}.
- **Sub-module `lbp_img_ram`:** single-port synchronous RAM, depth `IMG_PIX`, width `DATA_W`, 1-cycle registered read. Two instances:
  - gray: written in LOAD, read in SERVE.
  - result: written in SERVE, read in DONE.
- Port muxing and the state machine live in `lbp_host`.

## Test plan
- Load ramp (pixel i = i mod 256) → `gray_ready` rises exactly the cycle after beat 16383; `gray_req` with addr 300 → `gray_data`=44 one cycle later.
- Back-to-back `gray_req` with addr 0,1,2,16383 → `gray_data` sequence 0,1,2,255 on consecutive cycles; `err`=0.
- Write all 16384 results (`lbp_data` = addr[7:0] XOR 8'hA5), with `finish` in the same cycle as the last write → `done`=1, `wr_count`=16384, `err`=0; readback addr 258 → `rd_data`=8'hA7.
- `finish` after only 16000 writes → `done`=1, `err`=1; `lbp_valid` in DONE → no RAM change, `wr_count` unchanged.
- `lbp_valid` during LOAD, and `gray_addr`=16384 with `gray_req` (legal with a wider `ADDR_W`) → `err`=1, no RAM write, `gray_data` holds.
- Assert `reset`=0 halfway through SERVE → all outputs at reset values, `ld_ready`=1 after release, `gray_ready`=0 until a new full load completes.
